// File: rtl/count_seg_decode.sv
// count_seg_decode: scanned 3-digit 7-segment display decoder with per-digit settling and frame assembly.
// Optional macro SEG_ERR_CNT_EN adds ERR_CNT, a saturating count of SEG_ERR pulses.
module count_seg_decode #(
    parameter int STABLE_CNT = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [6:0] SEG_C,
    input  logic [7:0] SEG_SEL,
    output logic [3:0] BCD_1,
    output logic [3:0] BCD_10,
    output logic [3:0] BCD_100,
    output logic [9:0] VALUE,
    output logic       FRAME_DONE,
    output logic       VALID,
    output logic       SEG_ERR
`ifdef SEG_ERR_CNT_EN
    ,
    output logic [7:0] ERR_CNT
`endif
);
    typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

    localparam logic [3:0] LP_SAT = 4'(STABLE_CNT);
    localparam logic [3:0] LP_CAP = 4'(STABLE_CNT - 1);

    logic [6:0] r_seg, r_seg_prev;
    logic [7:0] r_sel, r_sel_prev;
    logic [3:0] r_cnt;
    state_t     r_state;
    logic [2:0] r_mask;
    logic [3:0] r_sh1, r_sh10, r_sh100;
    logic       r_pend;

    logic       w_chg, w_stable, w_sel_idle, w_sel_ok, w_dig_ok;
    logic       w_cap, w_err;
    logic [3:0] w_cnt_nxt, w_dig;
    logic [2:0] w_bit, w_mask_nxt;

    always_comb begin
        w_chg      = (r_seg != r_seg_prev) || (r_sel != r_sel_prev);
        w_cnt_nxt  = w_chg ? 4'd0 : ((r_cnt == LP_SAT) ? r_cnt : r_cnt + 4'd1);
        w_stable   = !w_chg && (w_cnt_nxt == LP_CAP);
        w_sel_idle = (r_sel == 8'hFF);
        w_bit      = 3'b000;
        case (r_sel)
            8'hFE:   w_bit = 3'b001;
            8'hFD:   w_bit = 3'b010;
            8'hFB:   w_bit = 3'b100;
            default: w_bit = 3'b000;
        endcase
        w_sel_ok = (w_bit != 3'b000);
        w_dig    = 4'd0;
        w_dig_ok = 1'b1;
        case (r_seg)
            7'h3f:   w_dig = 4'd0;
            7'h06:   w_dig = 4'd1;
            7'h5b:   w_dig = 4'd2;
            7'h4f:   w_dig = 4'd3;
            7'h66:   w_dig = 4'd4;
            7'h6d:   w_dig = 4'd5;
            7'h7c:   w_dig = 4'd6;
            7'h07:   w_dig = 4'd7;
            7'h7f:   w_dig = 4'd8;
            7'h67:   w_dig = 4'd9;
            default: w_dig_ok = 1'b0;
        endcase
        // Re-capturing a digit already in the mask starts a fresh frame from that digit.
        w_mask_nxt = ((r_mask & w_bit) != 3'b000) ? w_bit : (r_mask | w_bit);
        w_cap      = w_stable && (r_state == SETTLE);
        w_err      = (w_cap && !w_dig_ok)
                  || (w_stable && (r_state == IDLE) && !w_sel_ok && !w_sel_idle);
    end

    always_ff @(negedge CLK or posedge RESET) begin
        if (RESET) begin
            r_seg      <= 7'h00;
            r_sel      <= 8'hFF;
            r_seg_prev <= 7'h00;
            r_sel_prev <= 8'hFF;
            r_cnt      <= 4'd0;
            r_state    <= IDLE;
            r_mask     <= 3'b000;
            r_sh1      <= 4'd0;
            r_sh10     <= 4'd0;
            r_sh100    <= 4'd0;
            r_pend     <= 1'b0;
            BCD_1      <= 4'd0;
            BCD_10     <= 4'd0;
            BCD_100    <= 4'd0;
            VALUE      <= 10'd0;
            FRAME_DONE <= 1'b0;
            VALID      <= 1'b0;
            SEG_ERR    <= 1'b0;
        end else begin
            r_seg      <= SEG_C;
            r_sel      <= SEG_SEL;
            r_seg_prev <= r_seg;
            r_sel_prev <= r_sel;
            r_cnt      <= w_cnt_nxt;
            SEG_ERR    <= w_err;
            FRAME_DONE <= r_pend;
            r_pend     <= 1'b0;
            if (r_pend) begin
                BCD_1   <= r_sh1;
                BCD_10  <= r_sh10;
                BCD_100 <= r_sh100;
                VALUE   <= 10'(r_sh100) * 10'd100 + 10'(r_sh10) * 10'd10 + 10'(r_sh1);
                VALID   <= 1'b1;
                r_mask  <= 3'b000;
            end
            if (w_err)
                r_mask <= 3'b000;
            if (w_chg) begin
                r_state <= w_sel_ok ? SETTLE : IDLE;
            end else if (w_cap) begin
                r_state <= HELD;
                if (w_dig_ok) begin
                    if (w_bit[0]) r_sh1   <= w_dig;
                    if (w_bit[1]) r_sh10  <= w_dig;
                    if (w_bit[2]) r_sh100 <= w_dig;
                    r_mask <= w_mask_nxt;
                    // Only a hundreds capture closes a frame.
                    r_pend <= w_bit[2] && (w_mask_nxt == 3'b111);
                end
            end
        end
    end

`ifdef SEG_ERR_CNT_EN
    always_ff @(negedge CLK or posedge RESET) begin
        if (RESET)
            ERR_CNT <= 8'd0;
        else if (w_err && (ERR_CNT != 8'hFF))
            ERR_CNT <= ERR_CNT + 8'd1;
    end
`endif

endmodule

// File: tb/tb_count_seg_decode.sv
// Randomized + directed bench for count_seg_decode against a run-length based reference model.
module tb_count_seg_decode;
    localparam int S = 4;

    logic       CLK = 1'b1;
    logic       RESET;
    logic [6:0] SEG_C;
    logic [7:0] SEG_SEL;
    logic [3:0] BCD_1, BCD_10, BCD_100;
    logic [9:0] VALUE;
    logic       FRAME_DONE, VALID, SEG_ERR;
`ifdef SEG_ERR_CNT_EN
    logic [7:0] ERR_CNT;
`endif

    count_seg_decode #(.STABLE_CNT(S)) dut (
        .CLK(CLK), .RESET(RESET), .SEG_C(SEG_C), .SEG_SEL(SEG_SEL),
        .BCD_1(BCD_1), .BCD_10(BCD_10), .BCD_100(BCD_100), .VALUE(VALUE),
        .FRAME_DONE(FRAME_DONE), .VALID(VALID), .SEG_ERR(SEG_ERR)
`ifdef SEG_ERR_CNT_EN
        , .ERR_CNT(ERR_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    logic [6:0] PAT [10] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7c, 7'h07, 7'h7f, 7'h67};

    int n_vec, n_bad;
    int fd_cnt, err_cnt, fd_at;

    // reference model: run length of the current registered sample drives everything
    logic [7:0] m_sel;
    logic [6:0] m_seg;
    int         m_run;
    bit         m_pend, m_valid, m_fd, m_err;
    bit   [2:0] m_mask;
    int         m_sh [3];
    int         m_bcd [3];
    int         m_ecnt;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int seg_val(input logic [6:0] p);
        for (int i = 0; i < 10; i++)
            if (PAT[i] == p) return i;
        return -1;
    endfunction

    function automatic int sel_idx(input logic [7:0] s);
        case (s)
            8'hFE:   return 0;
            8'hFD:   return 1;
            8'hFB:   return 2;
            8'hFF:   return -1;
            default: return -2;
        endcase
    endfunction

    task automatic model_reset();
        m_sel = 8'hFF; m_seg = 7'h00; m_run = 2;
        m_pend = 0; m_valid = 0; m_fd = 0; m_err = 0; m_mask = 3'b000; m_ecnt = 0;
        for (int i = 0; i < 3; i++) begin m_sh[i] = 0; m_bcd[i] = 0; end
    endtask

    task automatic model_edge();
        int d, v;
        m_fd = 0; m_err = 0;
        if (m_pend) begin
            for (int i = 0; i < 3; i++) m_bcd[i] = m_sh[i];
            m_valid = 1; m_fd = 1; m_mask = 3'b000; m_pend = 0;
        end
        if (m_run == S) begin
            d = sel_idx(m_sel);
            v = seg_val(m_seg);
            if (d == -2 || (d >= 0 && v < 0)) begin
                m_err = 1; m_mask = 3'b000;
            end else if (d >= 0) begin
                m_sh[d] = v;
                if (m_mask[d]) m_mask = 3'b000;
                m_mask[d] = 1'b1;
                if (d == 2 && m_mask == 3'b111) m_pend = 1;
            end
        end
        if (m_err && m_ecnt < 255) m_ecnt++;
        if (SEG_SEL == m_sel && SEG_C == m_seg) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_sel = SEG_SEL; m_seg = SEG_C; m_run = 1;
        end
    endtask

    task automatic check_outs();
        chk("FRAME_DONE", int'(FRAME_DONE), int'(m_fd));
        chk("SEG_ERR", int'(SEG_ERR), int'(m_err));
        chk("VALID", int'(VALID), int'(m_valid));
        chk("VALUE", int'(VALUE), m_bcd[2] * 100 + m_bcd[1] * 10 + m_bcd[0]);
        chk("BCD", int'({BCD_100, BCD_10, BCD_1}), m_bcd[2] * 256 + m_bcd[1] * 16 + m_bcd[0]);
`ifdef SEG_ERR_CNT_EN
        chk("ERR_CNT", int'(ERR_CNT), m_ecnt);
`endif
    endtask

    task automatic cyc();
        @(negedge CLK);
        model_edge();
        #1;
        fd_cnt  += int'(FRAME_DONE);
        err_cnt += int'(SEG_ERR);
        check_outs();
    endtask

    task automatic hold(input logic [7:0] sel, input logic [6:0] seg, input int n);
        SEG_SEL = sel; SEG_C = seg;
        for (int i = 0; i < n; i++) begin
            cyc();
            if (FRAME_DONE && fd_at == 0) fd_at = i + 1;
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        #1;
        model_reset();
        chk("rst_VALUE", int'(VALUE), 0);
        chk("rst_VALID", int'(VALID), 0);
        chk("rst_BCD", int'({BCD_100, BCD_10, BCD_1}), 0);
        check_outs();
        RESET = 1'b0;
    endtask

    initial begin
        logic [7:0] sel;
        logic [6:0] seg;
        int         d, r;
        n_vec = 0; n_bad = 0; fd_cnt = 0; err_cnt = 0; fd_at = 0;
        RESET = 1'b0; SEG_SEL = 8'hFF; SEG_C = 7'h00;
        model_reset();
        #1;
        do_reset();

        // scan 3-2-0
        hold(8'hFE, 7'h3f, 10);
        hold(8'hFD, 7'h5b, 10);
        fd_cnt = 0; fd_at = 0;
        hold(8'hFB, 7'h4f, 10);
        chk("r027_fd", fd_cnt, 1);
        chk("r027_latency", fd_at, S + 2);
        chk("r027_value", int'(VALUE), 320);
        chk("r027_bcd", int'({BCD_100, BCD_10, BCD_1}), 12'h320);
        chk("r027_valid", int'(VALID), 1);

        // too short to settle
        fd_cnt = 0;
        hold(8'hFE, 7'h06, S - 2);
        hold(8'hFD, 7'h06, S - 2);
        hold(8'hFB, 7'h06, S - 2);
        chk("r028_fd", fd_cnt, 0);
        chk("r028_value", int'(VALUE), 320);

        // illegal tens pattern, then clean 9-9-9
        fd_cnt = 0; err_cnt = 0;
        hold(8'hFB, 7'h06, 10);
        hold(8'hFE, 7'h3f, 10);
        hold(8'hFD, 7'h7e, 10);
        chk("r029_err", err_cnt, 1);
        chk("r029_fd", fd_cnt, 0);
        hold(8'hFE, 7'h67, 10);
        hold(8'hFD, 7'h67, 10);
        hold(8'hFB, 7'h67, 10);
        chk("r029_value", int'(VALUE), 999);

        // repeated ones restarts the frame
        fd_cnt = 0;
        hold(8'hFE, 7'h06, 10);
        hold(8'hFE, 7'h07, 10);
        hold(8'hFD, 7'h4f, 10);
        hold(8'hFB, 7'h06, 10);
        chk("r030_fd", fd_cnt, 1);
        chk("r030_value", int'(VALUE), 137);

        // reset mid-frame
        hold(8'hFE, 7'h6d, 10);
        hold(8'hFD, 7'h66, 10);
        do_reset();
        fd_cnt = 0;
        hold(8'hFB, 7'h7f, 10);
        chk("r031_fd", fd_cnt, 0);
        chk("r031_valid", int'(VALID), 0);

        // randomized scans
        for (int f = 0; f < 80; f++) begin
            for (int k = 0; k < 3; k++) begin
                d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : k;
                sel = (d == 0) ? 8'hFE : (d == 1) ? 8'hFD : 8'hFB;
                r = int'($urandom_range(0, 19));
                if (r == 0) sel = 8'hFF;
                else if (r == 1) sel = 8'($urandom);
                seg = PAT[$urandom_range(0, 9)];
                if ($urandom_range(0, 9) == 0) seg = 7'($urandom);
                hold(sel, seg, int'($urandom_range(1, 8)));
            end
            if ($urandom_range(0, 29) == 0) do_reset();
        end

`ifdef SEG_ERR_CNT_EN
        for (int i = 0; i < 260; i++)
            hold(8'hFE, (i % 2 == 1) ? 7'h7e : 7'h00, S);
        chk("err_cnt_sat", int'(ERR_CNT), 255);
        hold(8'hFE, 7'h7e, S);
        chk("err_cnt_hold", int'(ERR_CNT), 255);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/count_seg_decode.md
COUNT_SEG_DECODE -- requirements
Module: count_seg_decode

Interface
REQ-001 Parameter STABLE_CNT, default 4; consecutive identical samples needed before a digit is accepted; legal range 2..15.
REQ-002 CLK  input  1  system clock; all state changes on negedge CLK.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 SEG_C  input  7  segment pattern, bit order gfe_dcba, active-high.
REQ-005 SEG_SEL  input  8  active-low digit select; 8'hFE = ones, 8'hFD = tens, 8'hFB = hundreds.
REQ-006 BCD_1, BCD_10, BCD_100  output  4 each  published digits of the last good frame.
REQ-007 VALUE  output  10  binary equivalent of the published digits: 100*BCD_100 + 10*BCD_10 + BCD_1, range 0..999.
REQ-008 FRAME_DONE  output  1  one-cycle pulse when a new frame is published.
REQ-009 VALID  output  1  high once any good frame has been published.
REQ-010 SEG_ERR  output  1  one-cycle pulse on an illegal pattern or select.

Function
REQ-011 SEG_C and SEG_SEL SHALL be registered once on input; all further logic uses the registered copies (1-cycle input latency).
REQ-012 A stability counter SHALL reset to 0 whenever either registered input differs from the previous sample, and otherwise increment, saturating at STABLE_CNT.
REQ-013 Per-digit FSM states: IDLE (select 8'hFF or illegal), SETTLE (legal select, counting), HELD (digit captured, wait for input change).
REQ-014 Transitions: IDLE->SETTLE on a legal select; SETTLE->HELD when the counter reaches STABLE_CNT-1, with one capture that cycle; HELD or SETTLE->IDLE or SETTLE on any input change; HELD never recaptures.
REQ-015 Capture SHALL decode SEG_C as 3f=0, 06=1, 5b=2, 4f=3, 66=4, 6d=5, 7c=6, 07=7, 7f=8, 67=9; any other pattern is illegal.
REQ-016 A legal capture SHALL write the digit into a shadow register selected by SEG_SEL and set that digit's bit in a 3-bit frame mask.
REQ-017 An illegal pattern at capture, or a stable (STABLE_CNT samples) select other than FE/FD/FB/FF, SHALL pulse SEG_ERR for one cycle and clear the frame mask.
REQ-018 A capture of a digit whose mask bit is already set SHALL restart the frame: the mask becomes that digit's bit only.
REQ-019 When a legal hundreds capture completes the mask to 3'b111, on the next cycle the shadows SHALL be copied to BCD_1/10/100, VALUE updated, FRAME_DONE pulsed, VALID set, and the mask cleared.
REQ-020 VALUE SHALL be registered, updating in the same cycle as the BCD outputs; the multiply-add uses at least 10-bit arithmetic.
REQ-021 Published outputs SHALL hold between frames; a bad frame never alters them.
REQ-022 Latency from the first select sample to FRAME_DONE for the final digit SHALL be 1 (input) + STABLE_CNT + 1 cycles.

Reset
REQ-023 RESET SHALL immediately force BCD_1/10/100=0, VALUE=0, FRAME_DONE=0, VALID=0, SEG_ERR=0, mask=0, shadows=0, stability counter=0, input registers=8'hFF/7'h00, and FSM=IDLE.
REQ-024 Reset during a frame SHALL discard the partial frame; the first post-reset frame SHALL need all three digits.

Configuration
REQ-025 Macro SEG_ERR_CNT_EN defined: an extra output ERR_CNT (8 bits) SHALL count SEG_ERR pulses, saturate at 255, and reset to 0.
REQ-026 Macro SEG_ERR_CNT_EN undefined: ERR_CNT port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-027 Scan FE/3f, FD/5b, FB/4f, each held 10 cycles -> FRAME_DONE once, BCD=3/2/0 (hundreds/tens/ones = 3,2,0), VALUE=320, VALID=1.
REQ-028 Each digit held only STABLE_CNT-2 cycles -> no capture, no FRAME_DONE, outputs unchanged.
REQ-029 Tens pattern 7'h7e -> SEG_ERR one pulse, no FRAME_DONE that frame; next clean frame 9/9/9 -> VALUE=999.
REQ-030 Sequence ones, ones, tens, hundreds -> one FRAME_DONE with the second ones value.
REQ-031 RESET asserted between tens and hundreds capture -> all outputs 0 at once, VALID=0; a hundreds-only scan after reset -> no FRAME_DONE.
REQ-032 With SEG_ERR_CNT_EN, 260 illegal captures -> ERR_CNT=255 and held.
